// File: rtl/pcie_phys_pkg.sv
// Shared PCIe PHY definitions: symbol width, K28.5 comma encodings and the
// lane serializer state encoding.
package pcie_phys_pkg;

    localparam int PCIE_SYMBOL_WIDTH = 10;

    localparam logic [PCIE_SYMBOL_WIDTH-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [PCIE_SYMBOL_WIDTH-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic {
        OFF   = 1'b0,
        SHIFT = 1'b1
    } lane_ser_state_e;

endpackage

// File: rtl/pcie_lane_serializer_if.sv
// Valid/ready symbol handshake between the 8b/10b encoder (master) and the
// lane serializer (slave).
interface pcie_lane_serializer_if
    import pcie_phys_pkg::*;
#(
    parameter int SYMBOL_WIDTH = PCIE_SYMBOL_WIDTH
);

    logic [SYMBOL_WIDTH-1:0] symbol_i;
    logic                    symbol_valid_i;
    logic                    symbol_ready_o;

    modport master (
        output symbol_i,
        output symbol_valid_i,
        input  symbol_ready_o
    );

    modport slave (
        input  symbol_i,
        input  symbol_valid_i,
        output symbol_ready_o
    );

endinterface

// File: rtl/pcie_lane_serializer.sv
// Per-lane TX serializer: holding register + shift register, LSB first, with
// idle-symbol fill on underrun. PCIE_LANE_SER_STATS_EN adds underrun_count_o.
module pcie_lane_serializer
    import pcie_phys_pkg::*;
#(
    parameter int                      SYMBOL_WIDTH = PCIE_SYMBOL_WIDTH,
    parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL  = SYMBOL_WIDTH'(K28_5_RDN),
    parameter int                      CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lane_enable_i,
    pcie_lane_serializer_if.slave sym,
    output logic                  serial_bit_o,
    output logic                  bit_valid_o,
    output logic                  symbol_start_o,
    output logic                  underrun_o
`ifdef PCIE_LANE_SER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  underrun_count_o
`endif
);

    localparam int                BCW      = $clog2(SYMBOL_WIDTH);
    localparam logic [BCW-1:0]    LAST_BIT = BCW'(SYMBOL_WIDTH - 1);

    lane_ser_state_e         state_q, state_d;
    logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [SYMBOL_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                    underrun_q, underrun_d;
    logic                    accept;

    // Ready is deliberately forced low during reset so nothing is taken then.
    assign sym.symbol_ready_o = lane_enable_i && !hold_valid_q && !rst_i;
    assign accept             = sym.symbol_valid_i && sym.symbol_ready_o;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        underrun_d   = 1'b0;

        // Accept never coincides with a hold consume: ready needs hold empty.
        if (accept) begin
            hold_d       = sym.symbol_i;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            OFF: begin
                bit_cnt_d = '0;
                if (!lane_enable_i) begin
                    hold_valid_d = 1'b0;
                end else if (hold_valid_q) begin
                    state_d      = SHIFT;
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (!lane_enable_i) begin
                    state_d      = OFF;
                    hold_valid_d = 1'b0;
                    bit_cnt_d    = '0;
                end else if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    bit_cnt_d    = '0;
                end else begin
                    // Boundary with nothing held: keep the wire busy with idle.
                    shift_d    = IDLE_SYMBOL;
                    bit_cnt_d  = '0;
                    underrun_d = 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= OFF;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            underrun_q   <= underrun_d;
        end
    end

    assign serial_bit_o   = shift_q[0];
    assign bit_valid_o    = (state_q == SHIFT);
    assign symbol_start_o = (state_q == SHIFT) && (bit_cnt_q == '0);
    assign underrun_o     = underrun_q;

`ifdef PCIE_LANE_SER_STATS_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (underrun_q && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign underrun_count_o = count_q;
`else
    logic cnt_width_unused;
    assign cnt_width_unused = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_pcie_lane_serializer.sv
// Directed bench for pcie_lane_serializer: start-up latency, back-to-back
// streaming, idle fill, disable and reset mid-symbol, counter saturation.
module tb_pcie_lane_serializer;
    import pcie_phys_pkg::*;

    localparam logic [9:0] IDLE = K28_5_RDN;

    logic clk;
    logic rst;
    logic en;
    logic serial_bit;
    logic bit_valid;
    logic symbol_start;
    logic underrun;
`ifdef PCIE_LANE_SER_STATS_EN
    logic [1:0] count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] src_q[$];
    logic fire;

    pcie_lane_serializer_if #(.SYMBOL_WIDTH(10)) sif ();

    pcie_lane_serializer #(
        .SYMBOL_WIDTH (10),
        .IDLE_SYMBOL  (IDLE),
        .CNT_WIDTH    (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lane_enable_i  (en),
        .sym            (sif.slave),
        .serial_bit_o   (serial_bit),
        .bit_valid_o    (bit_valid),
        .symbol_start_o (symbol_start),
        .underrun_o     (underrun)
`ifdef PCIE_LANE_SER_STATS_EN
        ,
        .underrun_count_o (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (src_q.size() > 0) begin
            sif.symbol_i       = src_q[0];
            sif.symbol_valid_i = 1'b1;
        end else begin
            sif.symbol_valid_i = 1'b0;
        end
    endtask

    task automatic push(input logic [9:0] s);
        src_q.push_back(s);
        drive();
    endtask

    // Advance one clock; handshake sampled mid-cycle, outputs checked at edge+1.
    task automatic step();
        #4;
        fire = sif.symbol_valid_i && sif.symbol_ready_o;
        @(posedge clk);
        #1;
        if (fire) void'(src_q.pop_front());
        drive();
    endtask

    task automatic expect_sym(input string tag, input logic [9:0] s, input logic exp_ur);
        for (int i = 0; i < 10; i++) begin
            step();
            check({tag, "_bit"},   serial_bit,   s[i]);
            check({tag, "_valid"}, bit_valid,    1'b1);
            check({tag, "_start"}, symbol_start, (i == 0));
            check({tag, "_ur"},    underrun,     (i == 0) && exp_ur);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sif.symbol_i       = '0;
        sif.symbol_valid_i = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();

        // Reset state
        check("rst_bit_valid", bit_valid,    1'b0);
        check("rst_serial",    serial_bit,   1'b0);
        check("rst_start",     symbol_start, 1'b0);
        check("rst_underrun",  underrun,     1'b0);
        en = 1'b1;
        #1;
        check("rst_ready", sif.symbol_ready_o, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", sif.symbol_ready_o, 1'b1);

        // Start-up latency, then back-to-back stream queued behind it
        push(10'h2AA);
        step();
        check("startup_gap", bit_valid, 1'b0);
        push(10'h3FF);
        push(10'h000);
        push(10'h155);
        expect_sym("s2aa", 10'h2AA, 1'b0);
        expect_sym("s3ff", 10'h3FF, 1'b0);
        expect_sym("s000", 10'h000, 1'b0);
        expect_sym("s155", 10'h155, 1'b0);

        // Underrun fill and counter saturation (width 2)
        expect_sym("idle1", IDLE, 1'b1);
        expect_sym("idle2", IDLE, 1'b1);
        expect_sym("idle3", IDLE, 1'b1);
`ifdef PCIE_LANE_SER_STATS_EN
        check("count_after3", count, 2'd3);
`endif
        expect_sym("idle4", IDLE, 1'b1);
        expect_sym("idle5", IDLE, 1'b1);
`ifdef PCIE_LANE_SER_STATS_EN
        check("count_sat", count, 2'd3);
`endif

        // Accepted on an empty boundary: idle goes out first, symbol next
        push(10'h0F0);
        expect_sym("idle6", IDLE, 1'b1);

        // Disable at bit 4 with another symbol held
        for (int i = 0; i < 10; i++) begin
            step();
            check("dis_bit",   serial_bit,   10'h0F0 >> i & 10'h1);
            check("dis_valid", bit_valid,    1'b1);
            check("dis_start", symbol_start, (i == 0));
            if (i == 0) push(10'h1C3);
            if (i == 4) en = 1'b0;
        end
        step();
        check("dis_off_valid", bit_valid,          1'b0);
        check("dis_off_start", symbol_start,       1'b0);
        check("dis_off_ready", sif.symbol_ready_o, 1'b0);
        step();
        check("dis_off_valid2", bit_valid, 1'b0);
        en = 1'b1;
        #1;
        check("held_discarded_ready", sif.symbol_ready_o, 1'b1);
        step();
        check("held_discarded_v1", bit_valid, 1'b0);
        step();
        check("held_discarded_v2", bit_valid, 1'b0);

        // Reset at bit 6, then restart
        push(10'h2E7);
        step();
        check("rst2_gap", bit_valid, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("rst2_bit",   serial_bit,   10'h2E7 >> i & 10'h1);
            check("rst2_start", symbol_start, (i == 0));
        end
        rst = 1'b1;
        step();
        check("midrst_valid",    bit_valid,          1'b0);
        check("midrst_serial",   serial_bit,         1'b0);
        check("midrst_start",    symbol_start,       1'b0);
        check("midrst_underrun", underrun,           1'b0);
        check("midrst_ready",    sif.symbol_ready_o, 1'b0);
`ifdef PCIE_LANE_SER_STATS_EN
        check("midrst_count", count, 2'd0);
`endif
        rst = 1'b0;
        push(10'h135);
        step();
        check("restart_gap", bit_valid, 1'b0);
        expect_sym("s135", 10'h135, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_lane_serializer.md
# pcie_lane_serializer

Per-lane TX serializer sitting directly downstream of the per-lane 8b/10b encoder and upstream of the electrical sub-block output bit (`electrical_sub_out_bits_o[lane]`). It accepts 10-bit encoded symbols over a valid/ready handshake and double-buffers them in a holding register plus a shift register. It emits one bit per clock, bit 0 first. If no symbol is ready at a symbol boundary, it inserts a configurable idle symbol so the wire never stalls mid-stream. One instance is built per lane.

## Interface
Parameters:
- `SYMBOL_WIDTH`, default 10: encoded symbol width in bits; must be ≥ 2.
- `IDLE_SYMBOL`, default `10'b0011111010`: fill symbol sent on underrun (K28.5, RD-).
- `CNT_WIDTH`, default 16: width of the underrun counter.

Ports:
- `clk_i`, in, 1: single clock for the block.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `lane_enable_i`, in, 1: lane enabled by the controller.
- `symbol_i`, in, `SYMBOL_WIDTH`: encoded symbol from the encoder.
- `symbol_valid_i`, in, 1: `symbol_i` is valid.
- `symbol_ready_o`, out, 1: block accepts `symbol_i` this cycle.
- `serial_bit_o`, out, 1: serialized bit to the electrical sub-block.
- `bit_valid_o`, out, 1: `serial_bit_o` carries a live bit.
- `symbol_start_o`, out, 1: high on the cycle the first bit (bit 0) of each symbol is on `serial_bit_o`.
- `underrun_o`, out, 1: one-cycle pulse when `IDLE_SYMBOL` is loaded because the holding register is empty.
- `underrun_count_o`, out, `CNT_WIDTH`: present only with `PCIE_LANE_SER_STATS_EN` (see Configuration).

## Operation
- **State:** a 2-state FSM, `OFF` and `SHIFT`.
- **Registers:**
  - `hold_q` and `hold_valid_q`
  - `shift_q`
  - `bit_cnt_q`, range 0..`SYMBOL_WIDTH-1`
- **Handshake:**
  - `symbol_ready_o = lane_enable_i && !hold_valid_q`. It is combinational from registered state and independent of `symbol_valid_i`.
  - A transfer occurs when valid and ready are both high. The symbol is written to `hold_q` and `hold_valid_q` sets.
- **Transition `OFF -> SHIFT`:** taken when `lane_enable_i && hold_valid_q`.
  - `shift_q` loads from `hold_q`.
  - `hold_valid_q` clears and `bit_cnt_q` goes to 0.
  - No idle symbol is ever inserted on start-up.
- **In `SHIFT`, when `bit_cnt_q < SYMBOL_WIDTH-1`:** `shift_q` shifts right by 1 and `bit_cnt_q` increments.
- **In `SHIFT`, when `bit_cnt_q == SYMBOL_WIDTH-1` (symbol boundary):**
  - If `lane_enable_i` is low, go to `OFF`. `hold_valid_q` is cleared and any pending held symbol is discarded.
  - Otherwise, if `hold_valid_q` is set, load `hold_q`, clear `hold_valid_q`, and set `bit_cnt_q` to 0.
  - Otherwise, load `IDLE_SYMBOL`, set `bit_cnt_q` to 0, and pulse `underrun_o` on the next cycle, aligned with `symbol_start_o`.
- **Disable mid-symbol:** the current symbol always completes; the wire never carries a truncated symbol.
- **Accept and load in the same cycle:** possible only when `hold_valid_q` is 0, so the load takes `IDLE_SYMBOL` and the new symbol lands in `hold_q` for the next boundary.
- **In `OFF`:** `shift_q` holds and `bit_cnt_q` stays 0. If `lane_enable_i` is low, `hold_valid_q` is cleared.

## Timing
- **Output derivation:**
  - `serial_bit_o = shift_q[0]`, registered.
  - `bit_valid_o = (state == SHIFT)`.
  - `symbol_start_o = (state == SHIFT) && bit_cnt_q == 0`.
- **Reset values:**
  - State is `OFF`.
  - `hold_valid_q`, `bit_cnt_q`, `shift_q`, all outputs and the counter are 0.
  - `symbol_ready_o` is 0 while `rst_i` is high.
- **Latency:** a symbol accepted in cycle t when the block is in `OFF` has its bit 0 on `serial_bit_o` at cycle t+2.
- **Throughput:** one symbol per `SYMBOL_WIDTH` cycles.
- **Back-to-back symbols:** there is no gap between them; the last bit of symbol N is immediately followed by bit 0 of symbol N+1.
- **Reset mid-symbol:** all state returns to reset values on the next edge, and the partial symbol is dropped.

## Configuration
- **Macro:** `PCIE_LANE_SER_STATS_EN`.
- **Defined:**
  - `underrun_count_o` exists.
  - It increments on each `underrun_o` pulse and saturates at all-ones.
  - It is cleared only by `rst_i`.
- **Undefined:** the port and counter are absent; `underrun_o` remains.

## Structure
- **Shared package `pcie_phys_pkg` holds:**
  - `PCIE_SYMBOL_WIDTH` = 10.
  - `K28_5_RDN` and `K28_5_RDP` constants.
  - The `lane_ser_state_e` enum (`OFF`, `SHIFT`).
- **Modules:** single module, with no sub-module; the holding register and shifter are too small to split.

## Test plan
- **Start-up latency:** enable=1, send one symbol `10'h2AA` at cycle t -> `bit_valid_o` rises at t+2; bits 0,1,0,1,… over 10 cycles; `symbol_start_o` is high at t+2 only.
- **Back-to-back symbols:** stream `10'h3FF`, `10'h000`, `10'h155` with valid held high -> 30 contiguous valid bits; `symbol_start_o` every 10 cycles; `underrun_o` never pulses.
- **Underrun fill:** one symbol, then valid=0 -> `IDLE_SYMBOL` bits follow immediately; `underrun_o` pulses at each idle boundary; with the macro defined the count is 3 after 3 idle symbols.
- **Disable mid-symbol:** drop enable at bit 4 -> remaining bits 5..9 are emitted; `bit_valid_o` falls after bit 9; a held symbol is discarded; `symbol_ready_o` is 0 while disabled.
- **Reset mid-symbol:** assert `rst_i` at bit 6 -> next cycle all outputs are 0 and state is `OFF`; re-enable and send a symbol -> first bit appears at t+2.
- **Counter saturation:** set `CNT_WIDTH`=2, run 5 consecutive underruns -> `underrun_count_o` = 3.
